fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001: The parameter line SHALL be `RESET_PC`, default 32'hBFC0_0000, the PC value loaded on reset.
- REQ-002: The parameter line SHALL be `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0), the instruction injected into ID on flush or reset.
- REQ-003: The port `clk` SHALL be input, 1 bit, the single clock; all state updates on the rising edge.
- REQ-004: The port `rst` SHALL be input, 1 bit; reset is synchronous and active-high.
- REQ-005: The port `PCWrite` SHALL be input, 1 bit; 1 = PC may advance, 0 = PC holds (load-use stall).
- REQ-006: The port `IF_ID_Write` SHALL be input, 1 bit; 1 = IF/ID register loads, 0 = IF/ID holds.
- REQ-007: The port `IF_ID_Flush` SHALL be input, 1 bit; 1 = IF/ID loads NOP_INSTR, and its `ValidD` output is cleared.
- REQ-008: The port `PCSrcE` SHALL be input, 1 bit; 1 = taken branch, jal or jalr resolved in EX.
- REQ-009: The port `PCTargetE` SHALL be input, 32 bits, the redirect target from EX.
- REQ-010: The port `PCF` SHALL be output, 32 bits, the current fetch address to instruction memory.
- REQ-011: The port `InstrF` SHALL be input, 32 bits, the instruction word returned combinationally for `PCF`.
- REQ-012: The ports `InstrD`, `PCD` and `PCPlus4D` SHALL be outputs, 32 bits each, holding the IF/ID register contents.
- REQ-013: The port `ValidD` SHALL be output, 1 bit; 1 = `InstrD` is a real fetched instruction, 0 = bubble.

Function
- REQ-014: `PCPlus4F` SHALL equal `PCF`+4, computed in 32-bit modulo arithmetic; 32'hFFFF_FFFC+4 SHALL wrap to 0.
- REQ-015: The next PC SHALL be selected with this priority:
  - `rst` selects RESET_PC;
  - otherwise `PCSrcE`=1 selects {`PCTargetE`[31:2],2'b00};
  - otherwise `PCWrite`=1 selects `PCPlus4F`;
  - otherwise the PC holds.
- REQ-016: The redirect SHALL override `PCWrite`=0 in the same cycle, so a stall never loses a taken branch.
- REQ-017: The IF/ID register SHALL update with this priority:
  - `rst` or `IF_ID_Flush` loads `InstrD`=NOP_INSTR, `PCD`=0, `PCPlus4D`=0, `ValidD`=0;
  - otherwise `IF_ID_Write`=1 loads `InstrF`, `PCF`, `PCPlus4F` and sets `ValidD`=1;
  - otherwise all IF/ID fields hold.
- REQ-018: Flush SHALL win over `IF_ID_Write`=0 when both are asserted in the same cycle.
- REQ-019: Fetch-to-ID latency SHALL be exactly one cycle: the instruction at `PCF` in cycle N appears on `InstrD` in cycle N+1 when neither stall nor flush is asserted.
- REQ-020: On a taken redirect in cycle N, `PCF` SHALL equal the aligned `PCTargetE` in cycle N+1, and the wrong-path instruction fetched in cycle N SHALL NOT reach ID with `ValidD`=1.
- REQ-021: A stall lasting K cycles (`PCWrite`=0, `IF_ID_Write`=0) SHALL hold `PCF`, `InstrD`, `PCD`, `PCPlus4D` and `ValidD` unchanged for K cycles; the next sequential instruction resumes on the first cycle after the stall.
- REQ-022: The block SHALL contain no combinational path from `InstrF` to `PCF`.

Reset
- REQ-023: While `rst`=1 at a rising edge, the block SHALL set `PCF`=RESET_PC, `InstrD`=NOP_INSTR, `PCD`=0, `PCPlus4D`=0 and `ValidD`=0, plus perf counters to 0 when enabled.
- REQ-024: Reset asserted mid-stall or coincident with `PCSrcE` SHALL win over all other controls.
- REQ-025: On the first edge after reset deasserts, the block SHALL fetch RESET_PC into ID.

Configuration
- REQ-026: With macro `FETCH_PERF_EN` defined, the block SHALL add two 32-bit outputs:
  - `StallCount` increments each non-reset cycle with `PCWrite`=0 and `PCSrcE`=0;
  - `FlushCount` increments each non-reset cycle with `IF_ID_Flush`=1;
  - both wrap at 2^32.
- REQ-027: Without `FETCH_PERF_EN`, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-028: Reset then release with `InstrF`=mem[PC] → `PCF` sequence BFC00000, BFC00004, BFC00008; `InstrD`=mem[BFC00000] with `ValidD`=1 one cycle after release.
- REQ-029: Load-use stall for 1 cycle at `PCF`=BFC00008 → `PCF` and `InstrD` held one cycle, then `PCF`=BFC0000C; with `FETCH_PERF_EN`, `StallCount`=1.
- REQ-030: `PCSrcE`=1, `PCTargetE`=BFC00103, `IF_ID_Flush`=1 → next `PCF`=BFC00100, `InstrD`=00000013, `ValidD`=0; with `FETCH_PERF_EN`, `FlushCount`=1.
- REQ-031: `PCSrcE`=1 together with `PCWrite`=0 and `IF_ID_Write`=0 → `PCF` takes the target, and ID is flushed if `IF_ID_Flush`=1.
- REQ-032: Force `PCF`=FFFFFFFC via redirect, then advance → `PCF`=00000000 and `PCPlus4D`=00000000 for that instruction.
- REQ-033: Assert `rst` during a 3-cycle stall → next `PCF`=BFC00000, `ValidD`=0, and counters cleared.

Source files
------------

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Groups the fetch stage's control, instruction-memory and IF/ID signals.
//   master : the fetch stage itself (drives PCF and the IF/ID outputs)
//   slave  : the rest of the core (hazard unit, EX redirect, instruction memory)
// Signals:
//   PCWrite, IF_ID_Write, IF_ID_Flush : hazard-unit controls into fetch
//   PCSrcE, PCTargetE                 : redirect request and target from EX
//   PCF, InstrF                       : fetch address out, instruction word in
//   InstrD, PCD, PCPlus4D, ValidD     : IF/ID register contents
//   StallCount, FlushCount            : perf counters, only with FETCH_PERF_EN
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;

  modport master (
    input  PCWrite, IF_ID_Write, IF_ID_Flush, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );
  modport slave (
    output PCWrite, IF_ID_Write, IF_ID_Flush, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );
`else
  modport master (
    input  PCWrite, IF_ID_Write, IF_ID_Flush, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD
  );
  modport slave (
    output PCWrite, IF_ID_Write, IF_ID_Flush, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of a 5-stage RISC-V pipeline: PC register, next-PC
// selection (reset > EX redirect > sequential advance > hold) and the IF/ID
// pipeline register (reset/flush > load > hold).
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fetch_stage_if.master (see interface for signal list)
// Parameters:
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : instruction placed in IF/ID on reset or flush
// Optional feature:
//   FETCH_PERF_EN : when defined, adds the 32-bit StallCount / FlushCount
//                   performance counters on the interface.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc_reg;
  logic [31:0] pc_plus4_f;
  logic [31:0] instr_d_reg;
  logic [31:0] pc_d_reg;
  logic [31:0] pc_plus4_d_reg;
  logic        valid_d_reg;

  // Natural 32-bit wrap: FFFF_FFFC + 4 = 0.
  assign pc_plus4_f = pc_reg + 32'd4;

  // PC register. The next PC depends only on registered PC and EX/hazard
  // controls, never on InstrF. A redirect beats PCWrite=0 so a stall cannot
  // swallow a taken branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else if (bus.PCSrcE) begin
      pc_reg <= {bus.PCTargetE[31:2], 2'b00};
    end else if (bus.PCWrite) begin
      pc_reg <= pc_plus4_f;
    end
  end

  // IF/ID register. Flush beats a held (IF_ID_Write=0) register.
  always_ff @(posedge clk) begin
    if (rst || bus.IF_ID_Flush) begin
      instr_d_reg    <= NOP_INSTR;
      pc_d_reg       <= 32'd0;
      pc_plus4_d_reg <= 32'd0;
      valid_d_reg    <= 1'b0;
    end else if (bus.IF_ID_Write) begin
      instr_d_reg    <= bus.InstrF;
      pc_d_reg       <= pc_reg;
      pc_plus4_d_reg <= pc_plus4_f;
      valid_d_reg    <= 1'b1;
    end
  end

  assign bus.PCF      = pc_reg;
  assign bus.InstrD   = instr_d_reg;
  assign bus.PCD      = pc_d_reg;
  assign bus.PCPlus4D = pc_plus4_d_reg;
  assign bus.ValidD   = valid_d_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_count_reg;
  logic [31:0] flush_count_reg;

  // A cycle with PCWrite=0 but a redirect still moves the PC, so it is not
  // counted as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_reg <= 32'd0;
      flush_count_reg <= 32'd0;
    end else begin
      if (!bus.PCWrite && !bus.PCSrcE) begin
        stall_count_reg <= stall_count_reg + 32'd1;
      end
      if (bus.IF_ID_Flush) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign bus.StallCount = stall_count_reg;
  assign bus.FlushCount = flush_count_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Instruction memory is modelled as
// mem[pc] = pc ^ 32'hFFFF_0000; expected values below are worked out by hand.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'hBFC0_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign bus.InstrF = bus.PCF ^ 32'hFFFF_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [31:0] pc4,
                          input logic valid);
    check({tag, ".InstrD"},   bus.InstrD,   instr);
    check({tag, ".PCD"},      bus.PCD,      pc);
    check({tag, ".PCPlus4D"}, bus.PCPlus4D, pc4);
    check({tag, ".ValidD"},   {31'd0, bus.ValidD}, {31'd0, valid});
  endtask

  task automatic check_perf(input string tag, input logic [31:0] stalls, input logic [31:0] flushes);
`ifdef FETCH_PERF_EN
    check({tag, ".StallCount"}, bus.StallCount, stalls);
    check({tag, ".FlushCount"}, bus.FlushCount, flushes);
`else
    if (stalls === 32'hx || flushes === 32'hx) $display("perf args undefined in %s", tag);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst             = 1'b1;
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    bus.IF_ID_Flush = 1'b0;
    bus.PCSrcE      = 1'b0;
    bus.PCTargetE   = 32'd0;

    // Reset state.
    step();
    step();
    check("reset.PCF", bus.PCF, 32'hBFC0_0000);
    check_id("reset", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
    check_perf("reset", 32'd0, 32'd0);
    $display("txn reset      PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // Release: first fetch reaches ID one cycle later.
    rst = 1'b0;
    step();
    check("run1.PCF", bus.PCF, 32'hBFC0_0004);
    check_id("run1", 32'h403F_0000, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1);
    $display("txn run1       PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    step();
    check("run2.PCF", bus.PCF, 32'hBFC0_0008);
    check_id("run2", 32'h403F_0004, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
    $display("txn run2       PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // One-cycle load-use stall at BFC00008.
    bus.PCWrite     = 1'b0;
    bus.IF_ID_Write = 1'b0;
    step();
    check("stall.PCF", bus.PCF, 32'hBFC0_0008);
    check_id("stall", 32'h403F_0004, 32'hBFC0_0004, 32'hBFC0_0008, 1'b1);
    check_perf("stall", 32'd1, 32'd0);
    $display("txn stall      PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    step();
    check("resume.PCF", bus.PCF, 32'hBFC0_000C);
    check_id("resume", 32'h403F_0008, 32'hBFC0_0008, 32'hBFC0_000C, 1'b1);
    $display("txn resume     PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // Taken redirect with flush, unaligned target.
    bus.PCSrcE      = 1'b1;
    bus.PCTargetE   = 32'hBFC0_0103;
    bus.IF_ID_Flush = 1'b1;
    step();
    check("redir.PCF", bus.PCF, 32'hBFC0_0100);
    check_id("redir", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
    check_perf("redir", 32'd1, 32'd1);
    $display("txn redirect   PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    bus.PCSrcE      = 1'b0;
    bus.IF_ID_Flush = 1'b0;
    step();
    check("target.PCF", bus.PCF, 32'hBFC0_0104);
    check_id("target", 32'h403F_0100, 32'hBFC0_0100, 32'hBFC0_0104, 1'b1);
    $display("txn target     PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // Redirect during stall with flush: redirect wins over PCWrite=0, flush over IF_ID_Write=0.
    bus.PCSrcE      = 1'b1;
    bus.PCTargetE   = 32'h0000_1000;
    bus.PCWrite     = 1'b0;
    bus.IF_ID_Write = 1'b0;
    bus.IF_ID_Flush = 1'b1;
    step();
    check("stredir.PCF", bus.PCF, 32'h0000_1000);
    check_id("stredir", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
    check_perf("stredir", 32'd1, 32'd2);
    $display("txn stall+redir PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    bus.PCSrcE      = 1'b0;
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    bus.IF_ID_Flush = 1'b0;
    step();
    check("t1000.PCF", bus.PCF, 32'h0000_1004);
    check_id("t1000", 32'hFFFF_1000, 32'h0000_1000, 32'h0000_1004, 1'b1);
    $display("txn fetch1000  PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // Redirect during stall without flush: PC moves, ID holds.
    bus.PCSrcE      = 1'b1;
    bus.PCTargetE   = 32'h0000_2002;
    bus.PCWrite     = 1'b0;
    bus.IF_ID_Write = 1'b0;
    step();
    check("hredir.PCF", bus.PCF, 32'h0000_2000);
    check_id("hredir", 32'hFFFF_1000, 32'h0000_1000, 32'h0000_1004, 1'b1);
    check_perf("hredir", 32'd1, 32'd2);
    $display("txn redir-hold PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // Wrap: redirect to FFFFFFFC then advance.
    bus.PCTargetE   = 32'hFFFF_FFFE;
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    step();
    check("wrapa.PCF", bus.PCF, 32'hFFFF_FFFC);
    check_id("wrapa", 32'hFFFF_2000, 32'h0000_2000, 32'h0000_2004, 1'b1);
    $display("txn wrap-set   PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    bus.PCSrcE = 1'b0;
    step();
    check("wrapb.PCF", bus.PCF, 32'h0000_0000);
    check_id("wrapb", 32'h0000_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    $display("txn wrap       PCF=%h InstrD=%h PCPlus4D=%h", bus.PCF, bus.InstrD, bus.PCPlus4D);

    // Reset in the middle of a 3-cycle stall, coincident with a redirect.
    bus.PCWrite     = 1'b0;
    bus.IF_ID_Write = 1'b0;
    step();
    step();
    check("mstall.PCF", bus.PCF, 32'h0000_0000);
    check_id("mstall", 32'h0000_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    check_perf("mstall", 32'd3, 32'd2);
    $display("txn stall2     PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);
    rst           = 1'b1;
    bus.PCSrcE    = 1'b1;
    bus.PCTargetE = 32'h0000_5000;
    step();
    check("rst2.PCF", bus.PCF, 32'hBFC0_0000);
    check_id("rst2", 32'h0000_0013, 32'd0, 32'd0, 1'b0);
    check_perf("rst2", 32'd0, 32'd0);
    $display("txn reset2     PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    // First edge after reset fetches RESET_PC into ID.
    rst             = 1'b0;
    bus.PCSrcE      = 1'b0;
    bus.PCWrite     = 1'b1;
    bus.IF_ID_Write = 1'b1;
    step();
    check("post.PCF", bus.PCF, 32'hBFC0_0004);
    check_id("post", 32'h403F_0000, 32'hBFC0_0000, 32'hBFC0_0004, 1'b1);
    $display("txn post-rst   PCF=%h InstrD=%h ValidD=%b", bus.PCF, bus.InstrD, bus.ValidD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
